// File: rtl/counter_seq_ctrl.sv
// Sequencer for a 4-bit counter: runs it for a requested number of full periods and pulses done.
// Optional COUNTER_SEQ_AUTORELOAD_EN: the final wrap reloads the run instead of ending it.
module counter_seq_ctrl #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WRAP_W-1:0] wraps,
   input  logic              stop,
   input  logic              hold,
   input  logic              cnt_co,
   output logic              cnt_en,
   output logic              cnt_rst,
   output logic              busy,
   output logic              done,
   output logic [WRAP_W-1:0] remaining
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [WRAP_W-1:0] remaining_q, remaining_d;
   logic [WRAP_W-1:0] wraps_lat_q, wraps_lat_d;
   logic              cnt_en_q, cnt_en_d;
   logic              cnt_rst_q, cnt_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              wrap_evt;

   // A terminal count only counts when the counter actually advanced through it.
   assign wrap_evt = cnt_en_q & cnt_co;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wraps_lat_d = wraps_lat_q;
      cnt_en_d    = cnt_en_q;
      cnt_rst_d   = cnt_rst_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_en_d    = 1'b0;
            cnt_rst_d   = 1'b1;
            remaining_d = '0;
            if (start) begin
               if (wraps != '0) begin
                  state_d     = S_RUN;
                  remaining_d = wraps;
                  wraps_lat_d = wraps;
                  cnt_rst_d   = 1'b0;
                  cnt_en_d    = ~hold;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            cnt_en_d  = ~hold;
            cnt_rst_d = 1'b0;
            if (stop) begin
               state_d     = S_IDLE;
               cnt_en_d    = 1'b0;
               cnt_rst_d   = 1'b1;
               remaining_d = '0;
            end else if (wrap_evt) begin
               if (remaining_q == WRAP_W'(1)) begin
                  done_d = 1'b1;
`ifdef COUNTER_SEQ_AUTORELOAD_EN
                  remaining_d = wraps_lat_q;
`else
                  state_d     = S_DONE;
                  cnt_en_d    = 1'b0;
                  cnt_rst_d   = 1'b1;
                  remaining_d = '0;
`endif
               end else begin
                  remaining_d = remaining_q - WRAP_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d   = S_IDLE;
            cnt_en_d  = 1'b0;
            cnt_rst_d = 1'b1;
         end
         default: begin
            state_d     = S_IDLE;
            cnt_en_d    = 1'b0;
            cnt_rst_d   = 1'b1;
            remaining_d = '0;
         end
      endcase
      busy_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         wraps_lat_q <= '0;
         cnt_en_q    <= 1'b0;
         cnt_rst_q   <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wraps_lat_q <= wraps_lat_d;
         cnt_en_q    <= cnt_en_d;
         cnt_rst_q   <= cnt_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cnt_en    = cnt_en_q;
   assign cnt_rst   = cnt_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;

endmodule
